// File: rtl/decode_stage_v2.sv
// MIPS ID stage: decode, register file with W->D bypass, branch/jump resolution
// and the D/E pipeline register feeding the execute stage.
module decode_stage_v2 #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic              d_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              fw_rs_en,
  input  logic              fw_rt_en,
  input  logic [DATA_W-1:0] fw_rs_val,
  input  logic [DATA_W-1:0] fw_rt_val,
  input  logic              w_we,
  input  logic [4:0]        w_a3,
  input  logic [DATA_W-1:0] w_wd,
  output logic [4:0]        d_rs,
  output logic [4:0]        d_rt,
  output logic [31:0]       npc,
  output logic              redirect,
  output logic              e_valid,
  output logic [31:0]       e_pc,
  output logic [31:0]       e_instr,
  output logic [DATA_W-1:0] e_rs_val,
  output logic [DATA_W-1:0] e_rt_val,
  output logic [DATA_W-1:0] e_imm,
  output logic [4:0]        e_a3,
  output logic [31:0]       e_link
);

  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
    return DATA_W'($signed(v));
  endfunction

  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic [4:0]        rs_a_s;
  logic [4:0]        rt_a_s;
  logic [4:0]        rd_a_s;
  logic [15:0]       imm16_s;
  logic [25:0]       imm26_s;
  logic              rf_we_s;
  logic              w_in_range_s;
  logic [AW-1:0]     rs_idx_s;
  logic [AW-1:0]     rt_idx_s;
  logic [DATA_W-1:0] rf_r [NREG];
  logic [DATA_W-1:0] rs_arr_s;
  logic [DATA_W-1:0] rt_arr_s;
  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;
  logic              rs_neg_s;
  logic              rs_zero_s;
  logic              rs_eq_rt_s;
  logic [31:0]       br_tgt_s;
  logic [31:0]       j_tgt_s;
  logic [DATA_W-1:0] imm_s;
  logic [4:0]        a3_s;
  logic              link_s;
  logic              taken_s;
  logic              jump_s;
  logic [31:0]       target_s;
  logic              bubble_s;

  assign op_s    = d_instr[31:26];
  assign rs_a_s  = d_instr[25:21];
  assign rt_a_s  = d_instr[20:16];
  assign rd_a_s  = d_instr[15:11];
  assign funct_s = d_instr[5:0];
  assign imm16_s = d_instr[15:0];
  assign imm26_s = d_instr[25:0];
  assign d_rs    = rs_a_s;
  assign d_rt    = rt_a_s;

  generate
    if (NREG >= 32) begin : g_full_range
      assign w_in_range_s = 1'b1;
    end else begin : g_part_range
      assign w_in_range_s = (w_a3 < 5'(NREG));
    end
  endgenerate

  assign rf_we_s = w_we && (w_a3 != 5'd0) && w_in_range_s;

  // Register 0 is never addressed by a write because rf_we_s excludes w_a3==0.
  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_rf
      // Register file entry: cleared on reset, loaded by the writeback port
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rf_r[g] <= {DATA_W{1'b0}};
        end else if (rf_we_s && (w_a3[AW-1:0] == AW'(g))) begin
          rf_r[g] <= w_wd;
        end
      end
    end
  endgenerate

  assign rs_idx_s = rs_a_s[AW-1:0];
  assign rt_idx_s = rt_a_s[AW-1:0];
  assign rs_arr_s = (rs_idx_s == {AW{1'b0}}) ? {DATA_W{1'b0}} : rf_r[rs_idx_s];
  assign rt_arr_s = (rt_idx_s == {AW{1'b0}}) ? {DATA_W{1'b0}} : rf_r[rt_idx_s];

  // Operand resolution: forwarding, then same-cycle writeback bypass, then array
  always_comb begin
    rs_val_s = rs_arr_s;
    rt_val_s = rt_arr_s;
    if (fw_rs_en) begin
      rs_val_s = fw_rs_val;
    end else if (w_we && (w_a3 == rs_a_s) && (rs_a_s != 5'd0)) begin
      rs_val_s = w_wd;
    end else begin
      rs_val_s = rs_arr_s;
    end
    if (fw_rt_en) begin
      rt_val_s = fw_rt_val;
    end else if (w_we && (w_a3 == rt_a_s) && (rt_a_s != 5'd0)) begin
      rt_val_s = w_wd;
    end else begin
      rt_val_s = rt_arr_s;
    end
  end

  assign rs_neg_s   = rs_val_s[DATA_W-1];
  assign rs_zero_s  = (rs_val_s == {DATA_W{1'b0}});
  assign rs_eq_rt_s = (rs_val_s == rt_val_s);
  assign br_tgt_s   = d_pc + 32'd4 + {{14{imm16_s[15]}}, imm16_s, 2'b00};
  assign j_tgt_s    = {d_pc[31:28], imm26_s, 2'b00};

  // Instruction decode: immediate, destination, branch condition and target
  always_comb begin
    imm_s    = sext32({{16{imm16_s[15]}}, imm16_s});
    a3_s     = 5'd0;
    link_s   = 1'b0;
    taken_s  = 1'b0;
    jump_s   = 1'b0;
    target_s = br_tgt_s;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_JR: begin
            jump_s   = 1'b1;
            target_s = rs_val_s[31:0];
          end
          FN_JALR: begin
            jump_s   = 1'b1;
            target_s = rs_val_s[31:0];
            a3_s     = rd_a_s;
            link_s   = 1'b1;
          end
          default: a3_s = rd_a_s;
        endcase
      end
      OP_REGIMM: begin
        case (rt_a_s)
          5'd0:    taken_s = rs_neg_s;
          5'd1:    taken_s = !rs_neg_s;
          default: taken_s = 1'b0;
        endcase
      end
      OP_J: begin
        jump_s   = 1'b1;
        target_s = j_tgt_s;
      end
      OP_JAL: begin
        jump_s   = 1'b1;
        target_s = j_tgt_s;
        a3_s     = 5'(LINK_REG);
        link_s   = 1'b1;
      end
      OP_BEQ:  taken_s = rs_eq_rt_s;
      OP_BNE:  taken_s = !rs_eq_rt_s;
      OP_BLEZ: taken_s = rs_neg_s || rs_zero_s;
      OP_BGTZ: taken_s = !rs_neg_s && !rs_zero_s;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_LB: a3_s = rt_a_s;
      OP_ANDI, OP_ORI, OP_XORI: begin
        a3_s  = rt_a_s;
        imm_s = DATA_W'(imm16_s);
      end
      OP_LUI: begin
        a3_s  = rt_a_s;
        imm_s = sext32({imm16_s, 16'h0000});
      end
      default: a3_s = 5'd0;
    endcase
  end

  // Next-PC selection; a stalled instruction cannot redirect fetch
  always_comb begin
    if (d_valid && !stall && (taken_s || jump_s)) begin
      redirect = 1'b1;
      npc      = target_s;
    end else begin
      redirect = 1'b0;
      npc      = f_pc + 32'd4;
    end
  end

  assign bubble_s = flush || stall || !d_valid;

  // D/E pipeline register with bubble insertion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid  <= 1'b0;
      e_pc     <= 32'd0;
      e_instr  <= 32'd0;
      e_rs_val <= {DATA_W{1'b0}};
      e_rt_val <= {DATA_W{1'b0}};
      e_imm    <= {DATA_W{1'b0}};
      e_a3     <= 5'd0;
      e_link   <= 32'd0;
    end else if (bubble_s) begin
      e_valid  <= 1'b0;
      e_pc     <= 32'd0;
      e_instr  <= 32'd0;
      e_rs_val <= {DATA_W{1'b0}};
      e_rt_val <= {DATA_W{1'b0}};
      e_imm    <= {DATA_W{1'b0}};
      e_a3     <= 5'd0;
      e_link   <= 32'd0;
    end else begin
      e_valid  <= 1'b1;
      e_pc     <= d_pc;
      e_instr  <= d_instr;
      e_rs_val <= rs_val_s;
      e_rt_val <= rt_val_s;
      e_imm    <= imm_s;
      e_a3     <= a3_s;
      e_link   <= link_s ? (d_pc + 32'd8) : 32'd0;
    end
  end

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed and randomized bench for decode_stage_v2 against an
// instruction-level reference model of the ID stage.
module tb_decode_stage_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc, d_pc, d_instr;
  logic        d_valid, stall, flush;
  logic        fw_rs_en, fw_rt_en;
  logic [31:0] fw_rs_val, fw_rt_val;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [4:0]  d_rs, d_rt;
  logic [31:0] npc;
  logic        redirect;
  logic        e_valid;
  logic [31:0] e_pc, e_instr, e_rs_val, e_rt_val, e_imm;
  logic [4:0]  e_a3;
  logic [31:0] e_link;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_rf [32];

  typedef struct packed {
    logic        redirect;
    logic [31:0] npc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic [4:0]  a3;
    logic [31:0] link;
  } exp_t;

  always #5 clk = ~clk;

  decode_stage_v2 dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .d_pc(d_pc), .d_instr(d_instr),
    .d_valid(d_valid), .stall(stall), .flush(flush),
    .fw_rs_en(fw_rs_en), .fw_rt_en(fw_rt_en), .fw_rs_val(fw_rs_val), .fw_rt_val(fw_rt_val),
    .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .d_rs(d_rs), .d_rt(d_rt),
    .npc(npc), .redirect(redirect), .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_imm(e_imm), .e_a3(e_a3), .e_link(e_link)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic fen, input logic [31:0] fv);
    if (fen) return fv;
    if (w_we && w_a3 == a && a != 5'd0) return w_wd;
    return m_rf[a];
  endfunction

  // Reference: what the ID stage should produce for the current inputs.
  function automatic exp_t model();
    exp_t e;
    logic [5:0] op = d_instr[31:26];
    logic [5:0] fn = d_instr[5:0];
    logic [4:0] rs = d_instr[25:21];
    logic [4:0] rt = d_instr[20:16];
    logic [4:0] rd = d_instr[15:11];
    logic [15:0] i16 = d_instr[15:0];
    logic [31:0] sx = {{16{i16[15]}}, i16};
    logic [31:0] rsv = operand(rs, fw_rs_en, fw_rs_val);
    logic [31:0] rtv = operand(rt, fw_rt_en, fw_rt_val);
    int srs = $signed(rsv);
    logic tk = 1'b0, jmp = 1'b0;
    logic [31:0] tgt = d_pc + 32'd4 + sx * 32'd4;
    e = '0;
    case (op)
      6'h04: tk = (rsv == rtv);
      6'h05: tk = (rsv != rtv);
      6'h06: tk = (srs <= 0);
      6'h07: tk = (srs > 0);
      6'h01: tk = (rt == 5'd0) ? (srs < 0) : (rt == 5'd1) ? (srs >= 0) : 1'b0;
      6'h02, 6'h03: begin jmp = 1'b1; tgt = {d_pc[31:28], d_instr[25:0], 2'b00}; end
      6'h00: if (fn == 6'h08 || fn == 6'h09) begin jmp = 1'b1; tgt = rsv; end
      default: tk = 1'b0;
    endcase
    e.redirect = d_valid && !stall && (tk || jmp);
    e.npc = e.redirect ? tgt : f_pc + 32'd4;
    if (flush || stall || !d_valid) return e;
    e.valid = 1'b1;
    e.pc = d_pc;
    e.instr = d_instr;
    e.rsv = rsv;
    e.rtv = rtv;
    if (op == 6'h0c || op == 6'h0d || op == 6'h0e) e.imm = {16'h0, i16};
    else if (op == 6'h0f) e.imm = {i16, 16'h0};
    else e.imm = sx;
    if (op == 6'h00) e.a3 = (fn == 6'h08) ? 5'd0 : rd;
    else if (op == 6'h03) e.a3 = 5'd31;
    else if (op inside {6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h20}) e.a3 = rt;
    else e.a3 = 5'd0;
    if (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) e.link = d_pc + 32'd8;
    return e;
  endfunction

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic step(input string name);
    exp_t e;
    #1;
    e = model();
    chk({name, "/redirect"}, {31'd0, redirect}, {31'd0, e.redirect});
    chk({name, "/npc"}, npc, e.npc);
    chk({name, "/d_rs"}, {27'd0, d_rs}, {27'd0, d_instr[25:21]});
    chk({name, "/d_rt"}, {27'd0, d_rt}, {27'd0, d_instr[20:16]});
    @(posedge clk);
    #1;
    chk({name, "/e_valid"}, {31'd0, e_valid}, {31'd0, e.valid});
    chk({name, "/e_pc"}, e_pc, e.pc);
    chk({name, "/e_instr"}, e_instr, e.instr);
    chk({name, "/e_rs_val"}, e_rs_val, e.rsv);
    chk({name, "/e_rt_val"}, e_rt_val, e.rtv);
    chk({name, "/e_imm"}, e_imm, e.imm);
    chk({name, "/e_a3"}, {27'd0, e_a3}, {27'd0, e.a3});
    chk({name, "/e_link"}, e_link, e.link);
    if (w_we && w_a3 != 5'd0) m_rf[w_a3] = w_wd;
    @(negedge clk);
  endtask

  task automatic quiet();
    d_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    fw_rs_en = 1'b0; fw_rt_en = 1'b0; fw_rs_val = 32'd0; fw_rt_val = 32'd0;
    w_we = 1'b0; w_a3 = 5'd0; w_wd = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    quiet();
    d_valid = 1'b0; d_instr = 32'd0;
    w_we = 1'b1; w_a3 = a; w_wd = v;
    step("wr");
    w_we = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 31));
    logic [15:0] im = 16'($urandom);
    case ($urandom_range(0, 19))
      0: return enc_r(rs, rt, rd, 6'h21);
      1: return enc_r(rs, 5'd0, 5'd0, 6'h08);
      2: return enc_r(rs, 5'd0, rd, 6'h09);
      3: return enc_j(6'h02, 26'($urandom));
      4: return enc_j(6'h03, 26'($urandom));
      5: return enc_i(6'h04, rs, rt, im);
      6: return enc_i(6'h05, rs, rt, im);
      7: return enc_i(6'h06, rs, 5'd0, im);
      8: return enc_i(6'h07, rs, 5'd0, im);
      9: return enc_i(6'h01, rs, 5'($urandom_range(0, 2)), im);
      10: return enc_i(6'h08, rs, rt, im);
      11: return enc_i(6'h0c, rs, rt, im);
      12: return enc_i(6'h0d, rs, rt, im);
      13: return enc_i(6'h0e, rs, rt, im);
      14: return enc_i(6'h0f, 5'd0, rt, im);
      15: return enc_i(6'h23, rs, rt, im);
      16: return enc_i(6'h2b, rs, rt, im);
      17: return enc_i(6'h20, rs, rt, im);
      18: return enc_i(6'h28, rs, rt, im);
      default: return enc_i(6'h0a, rs, rt, im);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    quiet();
    reset = 1'b0; f_pc = 32'h0000_5000; d_pc = 32'h0000_3000; d_instr = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset/e_valid", {31'd0, e_valid}, 32'd0);
    chk("reset/e_pc", e_pc, 32'd0);
    chk("reset/e_a3", {27'd0, e_a3}, 32'd0);
    reset = 1'b1;

    // Same-cycle writeback bypass of r5 into addu
    quiet();
    w_we = 1'b1; w_a3 = 5'd5; w_wd = 32'h0000_1234;
    d_instr = enc_r(5'd5, 5'd0, 5'd7, 6'h21);
    step("bypass");
    chk("bypass/rs_const", e_rs_val, 32'h0000_1234);
    quiet();
    w_we = 1'b1; w_a3 = 5'd0; w_wd = 32'hDEAD_BEEF;
    d_instr = enc_r(5'd0, 5'd5, 5'd7, 6'h21);
    step("w_r0");
    quiet();
    d_instr = enc_r(5'd0, 5'd0, 5'd7, 6'h21);
    step("r0_read");
    chk("r0_read/const", e_rs_val, 32'd0);

    wr(5'd1, 32'h55); wr(5'd2, 32'h55); wr(5'd3, 32'h66);
    wr(5'd4, 32'hFFFF_FFFF); wr(5'd6, 32'h1); wr(5'd8, 32'h3100);

    quiet();
    d_pc = 32'h3000; f_pc = 32'h5000;
    d_instr = enc_i(6'h04, 5'd1, 5'd2, 16'h0004);
    step("beq_taken");
    chk("beq_taken/npc_const", npc, 32'h3014);
    d_instr = enc_i(6'h04, 5'd1, 5'd3, 16'h0004);
    step("beq_nt");
    chk("beq_nt/npc_const", npc, 32'h5004);
    d_instr = enc_i(6'h01, 5'd4, 5'd0, 16'h0010);
    step("bltz");
    chk("bltz/redirect_const", {31'd0, redirect}, 32'd1);
    d_instr = enc_i(6'h01, 5'd0, 5'd1, 16'h0010);
    step("bgez0");
    chk("bgez0/redirect_const", {31'd0, redirect}, 32'd1);
    d_instr = enc_i(6'h06, 5'd6, 5'd0, 16'h0010);
    step("blez1");
    chk("blez1/redirect_const", {31'd0, redirect}, 32'd0);
    fw_rs_en = 1'b1; fw_rs_val = 32'd0;
    step("blez_fw");
    chk("blez_fw/redirect_const", {31'd0, redirect}, 32'd1);
    quiet();
    d_instr = enc_j(6'h03, 26'h0000C10);
    step("jal");
    chk("jal/npc_const", npc, 32'h0000_3040);
    chk("jal/a3_const", {27'd0, e_a3}, 32'd31);
    chk("jal/link_const", e_link, 32'h3008);
    d_instr = enc_r(5'd8, 5'd0, 5'd4, 6'h09);
    step("jalr");
    chk("jalr/npc_const", npc, 32'h3100);
    chk("jalr/a3_const", {27'd0, e_a3}, 32'd4);
    d_instr = enc_i(6'h0f, 5'd0, 5'd9, 16'hABCD);
    step("lui");
    chk("lui/imm_const", e_imm, 32'hABCD_0000);
    d_instr = enc_i(6'h0d, 5'd1, 5'd9, 16'h8000);
    step("ori");
    chk("ori/imm_const", e_imm, 32'h0000_8000);
    stall = 1'b1;
    d_instr = enc_i(6'h04, 5'd1, 5'd2, 16'h0004);
    step("beq_stall");
    chk("beq_stall/e_valid_const", {31'd0, e_valid}, 32'd0);
    quiet(); flush = 1'b1;
    step("beq_flush");
    quiet(); flush = 1'b1; stall = 1'b1;
    step("flush_stall");

    // Asynchronous reset while E holds a valid instruction
    quiet();
    d_instr = enc_r(5'd5, 5'd1, 5'd7, 6'h21);
    step("preload");
    d_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midreset/e_valid", {31'd0, e_valid}, 32'd0);
    chk("midreset/e_pc", e_pc, 32'd0);
    chk("midreset/e_rs_val", e_rs_val, 32'd0);
    chk("midreset/e_instr", e_instr, 32'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    quiet();
    d_instr = enc_r(5'd5, 5'd1, 5'd7, 6'h21);
    step("post_reset");
    chk("post_reset/rs_const", e_rs_val, 32'd0);
    chk("post_reset/rt_const", e_rt_val, 32'd0);

    for (int n = 0; n < 400; n++) begin
      d_valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      fw_rs_en = ($urandom_range(0, 4) == 0); fw_rs_val = pick_val();
      fw_rt_en = ($urandom_range(0, 4) == 0); fw_rt_val = pick_val();
      w_we = $urandom_range(0, 1) == 1; w_a3 = 5'($urandom_range(0, 7)); w_wd = pick_val();
      d_instr = rand_instr();
      d_pc = {$urandom, 2'b00} ^ {30'd0, 2'b00};
      f_pc = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_v2.md
Name: decode_stage_v2

Overview:
- Second-generation MIPS ID stage for the 5-stage pipeline: instruction decode, register file, W→D write-through bypass, branch/jump resolution and an owned D/E pipeline register.
- Generalised over the single-issue decode: parametrised register count, register data width and link register.
- Adds blez/bgtz/bltz/bgez/jalr/lui, stall/flush bubble insertion and registered E-stage outputs.
- Sits between the F/D register and the execute stage. The hazard unit drives stall/flush and forwarding.

Parameters:
- DATA_W, 32, register/operand width; ≥32. PC stays 32 bits. jr/jalr use rs[31:0].
- NREG, 32, register count (16 or 32). AW = $clog2(NREG); higher address bits ignored.
- LINK_REG, 31, destination of jal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- f_pc  in  32  current fetch PC
- d_pc  in  32  PC of instruction in D
- d_instr  in  32  instruction in D
- d_valid  in  1  D holds a real instruction
- stall  in  1  hazard stall; insert bubble into E
- flush  in  1  kill E next cycle
- fw_rs_en / fw_rt_en  in  1  forwarded value overrides read
- fw_rs_val / fw_rt_val  in  DATA_W  forwarded operands
- w_we  in  1  writeback enable
- w_a3  in  5  writeback register
- w_wd  in  DATA_W  writeback data
- d_rs / d_rt  out  5  decoded source addresses (to hazard unit)
- npc  out  32  next fetch PC
- redirect  out  1  npc is a taken branch/jump target
- e_valid  out  1  E register holds a real instruction
- e_pc  out  32
- e_instr  out  32
- e_rs_val / e_rt_val  out  DATA_W  resolved operands
- e_imm  out  DATA_W  extended immediate
- e_a3  out  5  destination; 0 = no write
- e_link  out  32  d_pc+8 for jal/jalr, else 0

Behaviour:
Register file
- NREG×DATA_W array; reg 0 reads 0 and ignores writes.
- Write on rising clk when w_we && w_a3!=0 && w_a3<NREG.
- Read is combinational.

Operand priority (rs and rt independently)
1. fw_*_en → fw_*_val
2. (w_we && w_a3==addr && addr!=0) → w_wd, the same-cycle bypass
3. array

Immediate extension
- Sign-extend: addi, addiu, slti, lw, sw, lb, sb, branches.
- Zero-extend: andi, ori, xori.
- lui: {imm16, 16'b0} sign-extended to DATA_W.

Destination (e_a3)
- R-type (op 0) and jalr: rd.
- jal: LINK_REG.
- I-type ALU/load: rt.
- sw, sb, branches, j, jr: 0.

Branch and jump resolution (combinational, delay-slot semantics)
- Comparisons are signed on resolved rs/rt.
- beq 000100: rs==rt
- bne 000101: rs!=rt
- blez 000110: rs≤0
- bgtz 000111: rs>0
- REGIMM 000001: rt field 0 = bltz (rs<0), rt field 1 = bgez (rs≥0)
- Taken branch target: d_pc+4+(sext(imm16)<<2).
- j/jal target: {d_pc[31:28], imm26, 2'b00}.
- jr/jalr target: rs[31:0].
- redirect=1 and npc=target when d_valid && !stall && taken/jump.
- Otherwise redirect=0 and npc=f_pc+4.
- Wrap-around is mod 2^32.

D/E register (posedge clk, async clear on reset=0)
- Reset or bubble: all E outputs 0; e_valid=0.
- Bubble when flush=1, or stall=1, or d_valid=0. flush and stall together → bubble.
- Otherwise E loads: d_pc, d_instr, resolved operands, imm, a3, link; e_valid=1.
- Reset mid-operation clears E immediately, independent of clk, and clears the register file.
- A W write and a D read of the same register in one cycle returns the new value (bypass path 2).

Latency
- npc/redirect/d_rs/d_rt: same cycle.
- E outputs: 1 cycle.

Test Plan:
- Reset low mid-run with E loaded → all E outputs 0 immediately; after release, reading any register gives 0.
- W writes r5=0x1234 while D decodes addu with rs=5 in the same cycle → e_rs_val=0x1234 next edge; w_a3=0 write leaves r0=0.
- beq, d_pc=0x3000, imm=0x0004, rs==rt → redirect=1, npc=0x3014; same with rs!=rt → redirect=0, npc=f_pc+4.
- bltz rs=0xFFFFFFFF → taken; bgez rs=0 → taken; blez rs=1 → not taken; fw_rs_en=1 with fw_rs_val overriding array value decides the outcome.
- jal, d_pc=0x3000, imm26=0x0000C10 → npc=0x00003040, e_a3=31, e_link=0x3008; jalr rd=4, rs=0x3100 → npc=0x3100, e_a3=4.
- lui imm=0xABCD → e_imm=0xABCD0000; ori imm=0x8000 → e_imm=0x00008000; stall=1 on valid beq → redirect=0, e_valid=0 next edge.
